nibble_serial_subtractor: RTL and testbench

Multi-cycle 32-bit subtractor for the KGP-RISC ALU's low-area build. It computes A − B four bits per cycle through a single registered borrow chain, the subtract-direction counterpart of the 4-bit carry-lookahead adder slice. It produces the difference and the branch/compare flags, and uses a start/busy/done handshake so the control unit can stall while it runs.

---
 rtl/nibble_serial_subtractor.sv | 134 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle 32-bit subtractor: one nibble per cycle through a registered borrow,
// start/busy/done handshake, difference plus borrow/zero/negative/overflow flags.
module nibble_serial_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        zero,
    output logic        negative,
    output logic        overflow
);

    localparam int DATA_W  = 32;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = DATA_W / NIB_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] res_next;
    logic [2:0]        k;
    logic              bin;
    logic              accept;
    logic              last;
    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [NIB_W-1:0]  d_nib;
    logic              bout;

    // 4-bit ripple borrow subtract: returns {borrow_out, difference}.
    function automatic logic [NIB_W:0] nibble_sub(input logic [NIB_W-1:0] x,
                                                  input logic [NIB_W-1:0] y,
                                                  input logic             bi);
        logic [NIB_W-1:0] d;
        logic [NIB_W:0]   br;
        br[0] = bi;
        for (int i = 0; i < NIB_W; i++) begin
            d[i]    = x[i] ^ y[i] ^ br[i];
            br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
        end
        return {br[NIB_W], d};
    endfunction

    function automatic logic sub_overflow(input logic sign_a,
                                          input logic sign_b,
                                          input logic sign_d);
        return (sign_a != sign_b) && (sign_d != sign_a);
    endfunction

    assign a_nib    = op_a[{k, 2'b00} +: NIB_W];
    assign b_nib    = op_b[{k, 2'b00} +: NIB_W];
    assign {bout, d_nib} = nibble_sub(a_nib, b_nib, bin);
    // Result nibbles enter at the top so nibble 0 lands in bits [3:0] after 8 shifts.
    assign res_next = {d_nib, res[DATA_W-1:NIB_W]};
    assign last     = (k == 3'(NIBBLES - 1));

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            k        <= '0;
            bin      <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_a <= a;
            op_b <= b;
            k    <= '0;
            bin  <= 1'b0;
        end else if (state == RUN) begin
            res <= res_next;
            bin <= bout;
            k   <= k + 3'd1;
            if (last) begin
                diff     <= res_next;
                borrow   <= bout;
                zero     <= (res_next == '0);
                negative <= res_next[DATA_W-1];
                overflow <= sub_overflow(op_a[DATA_W-1], op_b[DATA_W-1], res_next[DATA_W-1]);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed and randomized bench for nibble_serial_subtractor against an arithmetic model.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        negative;
    logic        overflow;

    int total;
    int passed;

    nibble_serial_subtractor dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference: {overflow, negative, zero, borrow, diff} from plain integer arithmetic.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        longint     sx;
        longint     sy;
        longint     r;
        logic [31:0] d;
        logic       ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = sx - sy;
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        d   = x - y;
        return {ovf, d[31], (d == 32'd0), (x < y), d};
    endfunction

    task automatic chk_result(input string tag, input logic [31:0] x, input logic [31:0] y);
        logic [35:0] m;
        m = model(x, y);
        chk({tag, ".diff"}, diff, m[31:0]);
        chk({tag, ".borrow"}, {31'd0, borrow}, {31'd0, m[32]});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, m[33]});
        chk({tag, ".negative"}, {31'd0, negative}, {31'd0, m[34]});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, m[35]});
    endtask

    // Waits (bounded) for done; returns cycles waited and busy cycles seen.
    task automatic wait_done(input logic [31:0] hold_diff, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == 4) chk("hold_diff", diff, hold_diff);
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int bc;
        logic [31:0] prev;
        prev  = diff;
        start = 1'b1;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_done(prev, lat, bc);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".latency"}, lat, 32'd8);
        chk({tag, ".busy_cycles"}, bc, 32'd8);
        chk_result(tag, x, y);
        step();
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int seen_done;
        logic [31:0] rx;
        logic [31:0] ry;
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.diff", diff, 32'd0);
        chk("rst.flags", {28'd0, borrow, zero, negative, overflow}, 32'd0);

        run_op("sub_5_3", 32'd5, 32'd3);
        run_op("sub_3_5", 32'd3, 32'd5);
        run_op("ovf_min", 32'h8000_0000, 32'd1);
        run_op("ovf_max", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op("zero_eq", 32'h1234_5678, 32'h1234_5678);
        run_op("nib_borrow", 32'h0000_0010, 32'h0000_0001);
        run_op("long_borrow", 32'h1000_0000, 32'h0000_0001);

        // Start during RUN must be ignored and leave the operands alone.
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd4;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        step();
        start = 1'b0;
        wait_done(diff, lat, bc);
        chk("ignored.done", {31'd0, done}, 32'd1);
        chk("ignored.diff", diff, 32'd5);
        step();
        chk("ignored.no_restart", {30'd0, busy, done}, 32'd0);

        // Back-to-back with start held high.
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd58;
        step();
        wait_done(diff, lat, bc);
        chk("b2b.first_done", {31'd0, done}, 32'd1);
        chk_result("b2b.first", 32'd100, 32'd58);
        a = 32'd7;
        b = 32'd9;
        step();
        start = 1'b0;
        chk("b2b.busy_after_accept", {30'd0, busy, done}, 32'd2);
        wait_done(diff, lat, bc);
        chk("b2b.gap", lat + 1, 32'd9);
        chk_result("b2b.second", 32'd7, 32'd9);
        step();

        // Reset in RUN cycle 4 aborts silently.
        start = 1'b1;
        a     = 32'h1234_5678;
        b     = 32'd1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst.diff", diff, 32'd0);
        chk("midrst.flags", {28'd0, borrow, zero, negative, overflow}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            step();
        end
        chk("midrst.no_done", seen_done, 32'd0);
        run_op("after_rst", 32'h0000_0100, 32'h0000_0001);

        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = $urandom;
            case (i % 6)
                0: ry = rx;
                1: rx = {1'b1, rx[30:0]};
                2: ry = {1'b0, ry[30:0]} | 32'h4000_0000;
                3: rx = rx & 32'h0000_00F0;
                default: ;
            endcase
            run_op("rand", rx, ry);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
